relu_max_skid_pipe: RTL and testbench



---
 rtl/relu_pool_pkg.sv | 30 +++
 rtl/relu_max_skid_pipe_skid.sv | 67 ++++++
 rtl/relu_max_skid_pipe.sv | 107 ++++++++++
 tb/tb_relu_max_skid_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pool_pkg.sv
// Shared types and lane helpers for the ReLU / max-pool output stage.
// Lane math runs at a wide signed width; callers sign-extend and truncate.
package relu_pool_pkg;

  localparam int LANE_W = 16;
  localparam int WIDE_W = 64;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic {
    EMPTY,
    HOLD
  } pool_state_e;

  function automatic wide_t relu_lane(
    input wide_t v,
    input logic  en
  );
    return (en && v[WIDE_W-1]) ? '0 : v;
  endfunction

  function automatic wide_t max_lane(
    input wide_t a,
    input wide_t b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_max_skid_pipe_skid.sv
// Two-entry output skid buffer (main + skid) with a registered ready.
// Ports: push/data in, ready out, out_valid/out_data/out_ready downstream.
module skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             drain;
  logic             main_valid_n;
  logic             skid_valid_n;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;

  assign drain = out_valid && out_ready;

  always_comb begin
    main_valid_n   = out_valid;
    skid_valid_n   = skid_valid;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (drain && skid_valid) begin
      main_load      = 1'b1;
      main_from_skid = 1'b1;
      main_valid_n   = 1'b1;
      skid_valid_n   = push;
      skid_load      = push;
    end else if (drain || !out_valid) begin
      main_load    = push;
      main_valid_n = push;
    end else if (push) begin
      skid_load    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready      <= 1'b0;
    end else begin
      out_valid  <= main_valid_n;
      skid_valid <= skid_valid_n;
      // ready only promises room once skid is known empty
      ready      <= !skid_valid_n;
      if (main_load)
        out_data <= main_from_skid ? skid_data : data;
      if (skid_load)
        skid_data <= data;
    end
  end

endmodule

// File: rtl/relu_max_skid_pipe.sv
// ReLU + optional 2:1 horizontal max-pool stage with skid-buffered output.
// Ports: clk, rst (async low), in_* beat/valid/ready/last, out_* likewise.
module relu_max_skid_pipe
  import relu_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int RELU_EN    = 1,
  parameter int MAX_POOL   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int W = CHANNELS*DATA_WIDTH;

  function automatic wide_t widen(
    input logic [DATA_WIDTH-1:0] x
  );
    return wide_t'({{(WIDE_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] narrow(
    input wide_t v
  );
    return v[DATA_WIDTH-1:0];
  endfunction

  logic         accept;
  logic         push;
  logic [W:0]   push_data;
  logic [W:0]   buf_data;
  logic [W-1:0] relu_beat;

  assign accept = in_valid && in_ready;

  always_comb begin
    relu_beat = '0;
    for (int k = 0; k < CHANNELS; k++)
      relu_beat[k*DATA_WIDTH +: DATA_WIDTH] = narrow(relu_lane(
        widen(in_data[k*DATA_WIDTH +: DATA_WIDTH]), RELU_EN != 0));
  end

  if (MAX_POOL != 0) begin : g_pool
    pool_state_e  state;
    logic [W-1:0] hold_reg;
    logic [W-1:0] max_beat;

    always_comb begin
      max_beat = '0;
      for (int k = 0; k < CHANNELS; k++)
        max_beat[k*DATA_WIDTH +: DATA_WIDTH] = narrow(max_lane(
          widen(hold_reg[k*DATA_WIDTH +: DATA_WIDTH]),
          widen(relu_beat[k*DATA_WIDTH +: DATA_WIDTH])));
    end

    // a lone last beat in EMPTY closes an odd-width row by itself
    assign push      = accept && (state == HOLD || in_last);
    assign push_data = (state == HOLD) ? {in_last, max_beat}
                                       : {in_last, relu_beat};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state    <= EMPTY;
        hold_reg <= '0;
      end else if (accept) begin
        unique case (state)
          EMPTY: begin
            if (!in_last) begin
              state    <= HOLD;
              hold_reg <= relu_beat;
            end
          end
          HOLD: state <= EMPTY;
        endcase
      end
    end
  end else begin : g_pass
    assign push      = accept;
    assign push_data = {in_last, relu_beat};
  end

  skid_buffer #(
    .WIDTH(W+1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .data     (push_data),
    .ready    (in_ready),
    .out_valid(out_valid),
    .out_data (buf_data),
    .out_ready(out_ready)
  );

  assign out_last = buf_data[W];
  assign out_data = buf_data[W-1:0];

endmodule

// File: tb/tb_relu_max_skid_pipe.sv
// Bench for relu_max_skid_pipe: passthrough and pooling instances,
// table vectors, scoreboard queues and multi-cycle corner sequences.
module tb_relu_max_skid_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] p_in_data = '0, q_in_data = '0;
  logic        p_in_valid = 0, q_in_valid = 0;
  logic        p_in_last = 0, q_in_last = 0;
  logic        p_in_ready, q_in_ready;
  logic [63:0] p_out_data, q_out_data;
  logic        p_out_valid, q_out_valid;
  logic        p_out_last, q_out_last;
  logic        p_out_ready = 1, q_out_ready = 1;

  relu_max_skid_pipe #(
    .DATA_WIDTH(16), .CHANNELS(4), .RELU_EN(1), .MAX_POOL(0)
  ) u_pass (
    .clk(clk), .rst(rst),
    .in_data(p_in_data), .in_valid(p_in_valid),
    .in_ready(p_in_ready), .in_last(p_in_last),
    .out_data(p_out_data), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .out_last(p_out_last)
  );

  relu_max_skid_pipe #(
    .DATA_WIDTH(16), .CHANNELS(4), .RELU_EN(1), .MAX_POOL(1)
  ) u_pool (
    .clk(clk), .rst(rst),
    .in_data(q_in_data), .in_valid(q_in_valid),
    .in_ready(q_in_ready), .in_last(q_in_last),
    .out_data(q_out_data), .out_valid(q_out_valid),
    .out_ready(q_out_ready), .out_last(q_out_last)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic [64:0] p_q[$];
  logic [64:0] q_q[$];
  bit          m_have = 0;
  logic [63:0] m_hold = '0;
  int p_outs = 0, q_outs = 0;
  int p_first_cyc = 0, p_last_cyc = 0;
  bit p_mark = 0;
  bit p_stall_prev = 0;
  logic [64:0] p_stall_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [63:0] relu4(input logic [63:0] d);
    logic [63:0] r;
    logic [15:0] l;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      l = d[k*16 +: 16];
      r[k*16 +: 16] = l[15] ? 16'h0 : l;
    end
    return r;
  endfunction

  function automatic logic [63:0] max4(input logic [63:0] a,
                                       input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[k*16 +: 16] = ($signed(a[k*16 +: 16]) > $signed(b[k*16 +: 16]))
                      ? a[k*16 +: 16] : b[k*16 +: 16];
    return r;
  endfunction

  task automatic model_pool(input logic [63:0] d, input logic last);
    logic [63:0] r;
    r = relu4(d);
    if (!m_have) begin
      if (last) q_q.push_back({1'b1, r});
      else begin m_have = 1; m_hold = r; end
    end else begin
      q_q.push_back({last, max4(m_hold, r)});
      m_have = 0;
    end
  endtask

  task automatic drive(input bit pool, input logic [63:0] d,
                       input logic last, output int waited);
    bit ok;
    waited = 0;
    ok = 0;
    if (pool) begin q_in_data = d; q_in_last = last; q_in_valid = 1; end
    else begin p_in_data = d; p_in_last = last; p_in_valid = 1; end
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (pool ? q_in_ready : p_in_ready) ok = 1;
      else waited++;
    end
    if (!ok) begin
      total++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
    end else if (pool) model_pool(d, last);
    else p_q.push_back({last, relu4(d)});
    @(posedge clk); #1;
    if (pool) q_in_valid = 0;
    else p_in_valid = 0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((p_q.size() != 0 || q_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("pass_queue_drained", 65'(p_q.size()), 65'd0);
    check("pool_queue_drained", 65'(q_q.size()), 65'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) p_stall_prev = 0;
    else begin
      if (p_stall_prev && p_out_valid)
        check("pass_stall_hold", {p_out_last, p_out_data}, p_stall_val);
      p_stall_prev = p_out_valid && !p_out_ready;
      p_stall_val = {p_out_last, p_out_data};
      if (p_out_valid && p_out_ready) begin
        p_outs++;
        p_last_cyc = cyc;
        if (p_mark) begin p_first_cyc = cyc; p_mark = 0; end
        if (p_q.size() == 0) begin
          total++;
          $display("FAIL pass_extra_beat: got %h required none",
                   {p_out_last, p_out_data});
        end else check("pass_beat", {p_out_last, p_out_data},
                       p_q.pop_front());
      end
      if (q_out_valid && q_out_ready) begin
        q_outs++;
        if (q_q.size() == 0) begin
          total++;
          $display("FAIL pool_extra_beat: got %h required none",
                   {q_out_last, q_out_data});
        end else check("pool_beat", {q_out_last, q_out_data},
                       q_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [63:0] din;
    logic        last;
    logic [63:0] dout;
  } vec_t;

  vec_t tv[4];

  function automatic logic [63:0] beat(input int i);
    return {16'(7 - i), 16'(i), 16'(-i), 16'(i * 1000 - 3000)};
  endfunction

  initial begin
    int w, wsum, base;
    tv[0] = '{{16'h8000, 16'h0000, 16'h0007, 16'hFFFB}, 1'b0,
              {16'h0000, 16'h0000, 16'h0007, 16'h0000}};
    tv[1] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 1'b1,
              {16'd4, 16'd3, 16'd2, 16'd1}};
    tv[2] = '{{16'd100, 16'h8001, 16'hFFFF, 16'h7FFF}, 1'b0,
              {16'd100, 16'h0000, 16'h0000, 16'h7FFF}};
    tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};

    // reset state
    #12;
    check("rst_out_valid", 65'(p_out_valid), 65'd0);
    check("rst_in_ready", 65'(p_in_ready), 65'd0);
    check("rst_out_data", 65'(p_out_data), 65'd0);
    check("rst_out_last", 65'(p_out_last), 65'd0);
    check("rst_pool_valid", 65'(q_out_valid), 65'd0);
    @(negedge clk);
    rst = 1;
    #1;
    check("rel_in_ready_before_edge", 65'(p_in_ready), 65'd0);
    @(posedge clk); #1;
    check("rel_in_ready_pass", 65'(p_in_ready), 65'd1);
    check("rel_in_ready_pool", 65'(q_in_ready), 65'd1);

    // table-driven passthrough, one-cycle latency
    foreach (tv[i]) begin
      drive(0, tv[i].din, tv[i].last, w);
      check("tv_valid", 65'(p_out_valid), 65'd1);
      check("tv_data", 65'(p_out_data), 65'(tv[i].dout));
      check("tv_last", 65'(p_out_last), 65'(tv[i].last));
    end
    wait_empty();

    // pooling pair
    base = q_outs;
    drive(1, {16'd2, 16'd9, 16'hFFFF, 16'd3}, 0, w);
    check("pair_first_silent", 65'(q_out_valid), 65'd0);
    drive(1, {16'd2, 16'hFFF7, 16'd6, 16'd4}, 1, w);
    check("pair_valid", 65'(q_out_valid), 65'd1);
    check("pair_data", 65'(q_out_data),
          65'({16'd2, 16'd9, 16'd6, 16'd4}));
    check("pair_last", 65'(q_out_last), 65'd1);
    wait_empty();
    check("pair_count", 65'(q_outs - base), 65'd1);

    // odd row width 3
    base = q_outs;
    drive(1, {16'hFFFC, 16'd3, 16'hFFFE, 16'd1}, 0, w);
    drive(1, {16'd2, 16'hFFFF, 16'd0, 16'd5}, 0, w);
    check("odd_max_data", 65'(q_out_data),
          65'({16'd2, 16'd3, 16'd0, 16'd5}));
    check("odd_max_last", 65'(q_out_last), 65'd0);
    drive(1, {16'd10, 16'd9, 16'd8, 16'hFFF9}, 1, w);
    check("odd_tail_data", 65'(q_out_data),
          65'({16'd10, 16'd9, 16'd8, 16'd0}));
    check("odd_tail_last", 65'(q_out_last), 65'd1);
    wait_empty();
    check("odd_count", 65'(q_outs - base), 65'd2);

    // backpressure on the passthrough instance
    base = p_outs;
    p_out_ready = 0;
    drive(0, beat(0), 0, w);
    check("bp_ready_after_one", 65'(p_in_ready), 65'd1);
    drive(0, beat(1), 0, w);
    check("bp_ready_fell", 65'(p_in_ready), 65'd0);
    check("bp_main_data", 65'(p_out_data), 65'(relu4(beat(0))));
    fork
      begin
        repeat (3) @(posedge clk);
        #1 p_out_ready = 1;
      end
    join_none
    for (int i = 2; i < 8; i++) drive(0, beat(i), i == 7, w);
    wait_empty();
    check("bp_count", 65'(p_outs - base), 65'd8);

    // reset while holding half a pair with main occupied
    q_out_ready = 0;
    drive(1, {16'd7, 16'd7, 16'd7, 16'd7}, 0, w);
    drive(1, {16'd8, 16'd8, 16'd8, 16'd8}, 0, w);
    drive(1, {16'd100, 16'd100, 16'd100, 16'd100}, 0, w);
    check("mid_main_full", 65'(q_out_valid), 65'd1);
    #2 rst = 0;
    #1;
    check("mid_rst_valid", 65'(q_out_valid), 65'd0);
    check("mid_rst_ready", 65'(q_in_ready), 65'd0);
    check("mid_rst_data", 65'(q_out_data), 65'd0);
    q_q.delete();
    p_q.delete();
    m_have = 0;
    q_out_ready = 1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("mid_rel_ready", 65'(q_in_ready), 65'd1);
    base = q_outs;
    drive(1, {16'd4, 16'd3, 16'd2, 16'd1}, 0, w);
    drive(1, {16'd1, 16'd2, 16'd3, 16'd4}, 1, w);
    check("mid_pair_data", 65'(q_out_data),
          65'({16'd4, 16'd3, 16'd3, 16'd4}));
    wait_empty();
    check("mid_pair_count", 65'(q_outs - base), 65'd1);

    // throughput: 64 back-to-back beats
    base = p_outs;
    wsum = 0;
    p_mark = 1;
    for (int i = 0; i < 64; i++) begin
      drive(0, beat(i), i == 63, w);
      wsum += w;
    end
    wait_empty();
    check("tp_no_stall", 65'(wsum), 65'd0);
    check("tp_count", 65'(p_outs - base), 65'd64);
    check("tp_consecutive", 65'(p_last_cyc - p_first_cyc), 65'd63);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
